// File: rtl/vga_pkg.sv
// Shared constants and FSM encoding for the VGA frame-buffer arbiter.
package vga_pkg;

   localparam int unsigned VGA_H_ACTIVE     = 640;
   localparam int unsigned VGA_V_ACTIVE     = 480;
   localparam int unsigned VGA_FRAME_PIXELS = VGA_H_ACTIVE * VGA_V_ACTIVE;
   localparam int unsigned VGA_PIX_W        = 12;

   typedef enum logic [1:0] {
      ST_FLUSH   = 2'd0,
      ST_PREFILL = 2'd1,
      ST_RUN     = 2'd2
   } arb_state_e;

endpackage

// File: rtl/px_fifo.sv
// Synchronous pixel FIFO with flush; a pop on an empty FIFO is ignored,
// so a same-cycle push into an empty FIFO is kept.
module px_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 12
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & ~flush & (~full | do_pop);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + AW'(1);
         if (do_pop)  rptr_d = rptr_q + AW'(1);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata;
   end

   assign rdata = mem_q[rptr_q];
   assign count = count_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display prefetch has priority over host
// writes; the prefetch FIFO is flushed and refilled at every vertical sync.
module vga_fb_arbiter
   import vga_pkg::*;
#(
   parameter int unsigned PIX_W           = VGA_PIX_W,
   parameter int unsigned ADDR_W          = 19,
   parameter int unsigned FRAME_PIXELS    = VGA_FRAME_PIXELS,
   parameter int unsigned FIFO_DEPTH      = 8,
   parameter bit          VS_ACTIVE_LEVEL = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              active_video_area,
   input  logic              vs,
   input  logic              host_valid,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [PIX_W-1:0]  host_data,
   output logic              host_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [PIX_W-1:0]  mem_wdata,
   input  logic [PIX_W-1:0]  mem_rdata,
   output logic [PIX_W-1:0]  pix_rgb,
   output logic              underflow
);

   localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned OCC_W = CW + 1;

   arb_state_e        state_q, state_d;
   logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
   logic [1:0]        inflight_q, inflight_d;
   logic              rd_pend_q, rd_pend_d;
   logic              live_q;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_rd_q, mem_rd_d;
   logic              mem_wr_q, mem_wr_d;
   logic [PIX_W-1:0]  mem_wdata_q, mem_wdata_d;
   logic [PIX_W-1:0]  pix_rgb_q, pix_rgb_d;
   logic              underflow_q, underflow_d;

   logic [CW-1:0]     fifo_count;
   logic              fifo_empty, fifo_full, fifo_flush;
   logic [PIX_W-1:0]  fifo_rdata;
   logic [OCC_W-1:0]  occ;
   logic              need, fetch_grant, host_grant;

   px_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PIX_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst),
      .push  (rd_pend_q),
      .wdata (mem_rdata),
      .pop   (active_video_area),
      .flush (fifo_flush),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign occ  = OCC_W'(fifo_count) + OCC_W'(inflight_q);
   assign need = (occ < OCC_W'(FIFO_DEPTH));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_FLUSH;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_FLUSH:   if (inflight_q == '0) state_d = ST_PREFILL;
         ST_PREFILL: if (!need)            state_d = ST_RUN;
         ST_RUN:     state_d = ST_RUN;
         default:    state_d = ST_FLUSH;
      endcase
      if (vs == VS_ACTIVE_LEVEL) state_d = ST_FLUSH;
   end

   // live_q keeps host_ready low while reset is held, even though FLUSH grants.
   always_comb begin
      fifo_flush  = (state_q == ST_FLUSH);
      fetch_grant = ((state_q == ST_PREFILL) || (state_q == ST_RUN)) && need;
      host_ready  = live_q && ((state_q == ST_FLUSH) || ((state_q == ST_RUN) && !need));
   end

   assign host_grant = host_valid & host_ready;

   always_comb begin
      fetch_addr_d = fetch_addr_q;
      if (fifo_flush) begin
         fetch_addr_d = '0;
      end else if (fetch_grant) begin
         fetch_addr_d = (fetch_addr_q == ADDR_W'(FRAME_PIXELS - 1)) ? '0 : fetch_addr_q + ADDR_W'(1);
      end
      inflight_d  = inflight_q + 2'(fetch_grant) - 2'(rd_pend_q);
      rd_pend_d   = mem_rd_q;
      mem_rd_d    = fetch_grant;
      mem_wr_d    = host_grant & ~fetch_grant;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if (fetch_grant) begin
         mem_addr_d = fetch_addr_q;
      end else if (host_grant) begin
         mem_addr_d  = host_addr;
         mem_wdata_d = host_data;
      end
      pix_rgb_d   = (active_video_area && !fifo_empty) ? fifo_rdata : '0;
      underflow_d = underflow_q | (active_video_area & fifo_empty);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_addr_q <= '0;
         inflight_q   <= '0;
         rd_pend_q    <= 1'b0;
         live_q       <= 1'b0;
         mem_addr_q   <= '0;
         mem_rd_q     <= 1'b0;
         mem_wr_q     <= 1'b0;
         mem_wdata_q  <= '0;
         pix_rgb_q    <= '0;
         underflow_q  <= 1'b0;
      end else begin
         fetch_addr_q <= fetch_addr_d;
         inflight_q   <= inflight_d;
         rd_pend_q    <= rd_pend_d;
         live_q       <= 1'b1;
         mem_addr_q   <= mem_addr_d;
         mem_rd_q     <= mem_rd_d;
         mem_wr_q     <= mem_wr_d;
         mem_wdata_q  <= mem_wdata_d;
         pix_rgb_q    <= pix_rgb_d;
         underflow_q  <= underflow_d;
      end
   end

   // Occupancy accounting must never let a returning word hit a full FIFO.
   assert property (@(posedge clk) disable iff (!rst) !(fifo_full && rd_pend_q));

   assign mem_addr  = mem_addr_q;
   assign mem_rd    = mem_rd_q;
   assign mem_wr    = mem_wr_q;
   assign mem_wdata = mem_wdata_q;
   assign pix_rgb   = pix_rgb_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed + randomized bench for vga_fb_arbiter against a frame-level pixel
// model (k-th visible pixel of a frame = word at address k mod frame size).
module tb_vga_fb_arbiter;

   localparam int unsigned PIX_W  = 12;
   localparam int unsigned ADDR_W = 19;
   localparam int unsigned FRAME  = 1000;

   logic              clk = 1'b0;
   logic              rst, av, vs, host_valid, host_ready;
   logic [ADDR_W-1:0] host_addr, mem_addr;
   logic [PIX_W-1:0]  host_data, mem_wdata, mem_rdata, pix_rgb;
   logic              mem_rd, mem_wr, underflow;

   int n_cmp  = 0;
   int n_fail = 0;
   int k      = 0;

   always #5 clk = ~clk;

   vga_fb_arbiter #(
      .PIX_W           (PIX_W),
      .ADDR_W          (ADDR_W),
      .FRAME_PIXELS    (FRAME),
      .FIFO_DEPTH      (8),
      .VS_ACTIVE_LEVEL (1'b0)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .active_video_area (av),
      .vs                (vs),
      .host_valid        (host_valid),
      .host_addr         (host_addr),
      .host_data         (host_data),
      .host_ready        (host_ready),
      .mem_addr          (mem_addr),
      .mem_rd            (mem_rd),
      .mem_wr            (mem_wr),
      .mem_wdata         (mem_wdata),
      .mem_rdata         (mem_rdata),
      .pix_rgb           (pix_rgb),
      .underflow         (underflow)
   );

   // SRAM model: word content equals its address; garbage when not reading.
   always @(posedge clk) mem_rdata <= mem_rd ? mem_addr[PIX_W-1:0] : '1;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_host();
      host_valid = ($urandom_range(0, 3) == 0);
      host_addr  = ADDR_W'($urandom);
      host_data  = PIX_W'($urandom);
   endtask

   // One clock with handshake and pixel-stream checking.
   task automatic cycle(input bit pix_chk);
      bit                acc, av_s;
      logic [ADDR_W-1:0] a;
      logic [PIX_W-1:0]  d;
      acc  = host_valid & host_ready;
      av_s = av;
      a    = host_addr;
      d    = host_data;
      tick();
      check("mem_wr", mem_wr, acc);
      if (acc) begin
         check("wr_addr", mem_addr, a);
         check("wr_data", mem_wdata, d);
      end
      check("rd_wr_excl", mem_rd & mem_wr, 0);
      if (pix_chk) begin
         check("pix", pix_rgb, av_s ? (k % FRAME) : 0);
         if (av_s) k++;
      end
   endtask

   task automatic wait_rd(input string tag);
      for (int i = 0; i < 16 && mem_rd !== 1'b1; i++) tick();
      check(tag, mem_rd, 1);
   endtask

   task automatic reset_values(input string tag);
      check({tag, "_mem_rd"}, mem_rd, 0);
      check({tag, "_mem_wr"}, mem_wr, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_mem_wdata"}, mem_wdata, 0);
      check({tag, "_pix"}, pix_rgb, 0);
      check({tag, "_underflow"}, underflow, 0);
      check({tag, "_host_ready"}, host_ready, 0);
   endtask

   initial begin
      rst = 1'b1; vs = 1'b0; av = 1'b0;
      host_valid = 1'b0; host_addr = '0; host_data = '0;
      #1 rst = 1'b0;
      repeat (3) tick();
      reset_values("reset");

      rst = 1'b1;
      tick(); tick();
      check("flush_ready", host_ready, 1);
      check("flush_no_rd", mem_rd, 0);

      // Prefill: eight back-to-back reads from address 0, host locked out.
      vs = 1'b1;
      wait_rd("prefill_start");
      for (int i = 0; i < 8; i++) begin
         check("prefill_rd", mem_rd, 1);
         check("prefill_addr", mem_addr, i);
         check("prefill_ready", host_ready, 0);
         tick();
      end
      check("prefill_done_rd", mem_rd, 0);
      check("run_full_ready", host_ready, 1);

      host_valid = 1'b1; host_addr = 19'h100; host_data = 12'hABC;
      check("hw_ready", host_ready, 1);
      tick();
      host_valid = 1'b0;
      check("hw_wr", mem_wr, 1);
      check("hw_addr", mem_addr, 19'h100);
      check("hw_data", mem_wdata, 12'hABC);
      check("hw_no_rd", mem_rd, 0);

      for (int i = 0; i < 640; i++) begin
         av = 1'b1; rand_host(); cycle(1);
         check("av_ready_low", host_ready, 0);
      end
      for (int i = 0; i < 160; i++) begin
         av = 1'b0; rand_host(); cycle(1);
      end
      check("blank_underflow", underflow, 0);
      check("blank_ready", host_ready, 1);

      // Second line crosses the frame-size wrap of the fetch address.
      for (int i = 0; i < 640; i++) begin
         av = 1'b1; rand_host(); cycle(1);
      end

      // vs mid-line while reads are in flight.
      av = 1'b0; vs = 1'b0; host_valid = 1'b0;
      cycle(1);
      k = 0;
      for (int i = 0; i < 4; i++) cycle(1);
      check("vs_flush_ready", host_ready, 1);
      vs = 1'b1;
      wait_rd("frame2_start");
      check("frame2_addr0", mem_addr, 0);
      repeat (12) tick();
      for (int i = 0; i < 8; i++) begin
         av = 1'b1; cycle(1);
         av = 1'b0; cycle(1);
      end
      check("frame2_underflow", underflow, 0);

      // Active video too soon after vs.
      vs = 1'b0;
      repeat (4) tick();
      vs = 1'b1;
      tick(); tick();
      av = 1'b1;
      tick();
      av = 1'b0;
      check("uf_pix", pix_rgb, 0);
      check("uf_flag", underflow, 1);
      repeat (20) tick();
      check("uf_sticky", underflow, 1);

      av = 1'b1;
      repeat (3) tick();
      check("pre_reset_pix", pix_rgb, 2);
      #2 rst = 1'b0;
      #1;
      reset_values("midrun_reset");
      av = 1'b0; vs = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      vs = 1'b1;
      wait_rd("restart");
      check("restart_addr0", mem_addr, 0);
      for (int i = 1; i < 8; i++) begin
         tick();
         check("restart_rd", mem_rd, 1);
         check("restart_addr", mem_addr, i);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port frame-buffer SRAM between two users: display scanout, which feeds the pixel stream, and a host writer, which updates the image.
- Sits between dispaly_timing_controller (consumes its active_video_area and vs) and the memory port.
- Prefetches pixels into a small FIFO so the display never waits. The host gets the remaining memory slots through a valid/ready handshake.

Parameters:
- PIX_W, 12, pixel width (RGB444).
- ADDR_W, 19, frame-buffer word address width; one word holds one pixel.
- FRAME_PIXELS, 307200, pixels per frame (640x480).
- FIFO_DEPTH, 8, prefetch FIFO depth; must be a power of 2 and at least 4.
- VS_ACTIVE_LEVEL, 0, level of vs during the sync pulse.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous reset, active-low.
- active_video_area  in  1  from the timing controller; the pixel of the next cycle is visible.
- vs  in  1  vertical sync from the timing controller.
- host_valid  in  1  host write request.
- host_addr  in  ADDR_W  host write address.
- host_data  in  PIX_W  host write data.
- host_ready  out  1  host write accepted this cycle when host_valid is also high.
- mem_addr  out  ADDR_W  registered SRAM address.
- mem_rd  out  1  registered read strobe.
- mem_wr  out  1  registered write strobe.
- mem_wdata  out  PIX_W  registered write data.
- mem_rdata  in  PIX_W  read data, valid the cycle after mem_rd.
- pix_rgb  out  PIX_W  registered pixel to the DAC; 0 outside active video.
- underflow  out  1  sticky flag, set when the FIFO is empty during active video.

Behaviour:
- Reset values (rst low, asynchronous): state=FLUSH, FIFO empty, fetch_addr=0, inflight=0, mem_rd=mem_wr=0, mem_addr=0, mem_wdata=0, pix_rgb=0, underflow=0, host_ready=0.
- Read pipeline: a grant in cycle N drives mem_rd and mem_addr in N+1. mem_rdata is written into the FIFO in N+2. inflight (0..2) counts granted reads whose data has not returned.
- occ = FIFO count + inflight. A display fetch is needed when occ < FIFO_DEPTH.
- FSM states:
  - FLUSH: entered on reset or whenever vs == VS_ACTIVE_LEVEL, from any state.
    - FIFO cleared; fetch_addr=0; returning read data discarded; no new reads granted.
    - host_ready = 1.
    - Exit to PREFILL when vs is inactive and inflight == 0.
  - PREFILL: grants display fetches only, host_ready = 0. Exit to RUN when occ == FIFO_DEPTH.
  - RUN: per cycle, a needed display fetch has absolute priority. Otherwise host_ready = 1.
- host_ready is combinational from registered state and occ only. It never depends on host_valid.
- Host write: on host_valid & host_ready in cycle N, mem_wr, mem_addr=host_addr and mem_wdata=host_data are driven in N+1. At most one memory operation is issued per cycle.
- fetch_addr increments on each granted fetch. After FRAME_PIXELS-1 it wraps to 0.
- Pop: in any state, active_video_area=1 pops one FIFO entry, and pix_rgb takes that entry next cycle.
  - Active video with an empty FIFO: pix_rgb=0 and underflow is set; underflow is cleared only by reset.
  - active_video_area=0: pix_rgb=0 next cycle.
- Pop and FIFO write in the same cycle: count unchanged, data order preserved. This also applies to an empty FIFO with an arriving word: the word is stored and the pop registers as underflow.
- A vs assertion mid-line discards FIFO contents immediately, with no corruption of later frames.

Decomposition:
- Package vga_pkg: FSM state encoding (FLUSH, PREFILL, RUN), default frame constants (640, 480, FRAME_PIXELS), PIX_W.
- One sub-module, px_fifo: synchronous FIFO with DEPTH, WIDTH, push, pop, flush, count, empty and full.
- The arbiter/FSM, fetch address counter and inflight counter live in vga_fb_arbiter.

Test Plan:
- Reset: assert rst low mid-RUN -> all outputs at reset values immediately; after release and a vs pulse, fetches restart at address 0.
- Prefill: release vs to inactive; memory model returns rdata=addr -> mem_rd at addresses 0..7 on 8 consecutive cycles, host_ready=0 throughout, then state RUN.
- Streaming: drive a 640-cycle active_video_area burst after prefill -> pix_rgb=0,1,2,...,639 on consecutive cycles, underflow stays 0.
- Host write: hold host_valid with addr=0x100, data=0xABC during horizontal blank with the FIFO full -> host_ready=1, next cycle mem_wr=1, mem_addr=0x100, mem_wdata=0xABC. During active video with occ<8 -> host_ready=0.
- Underflow: assert active_video_area 2 cycles after vs deasserts -> pix_rgb=0 and underflow=1, sticky until reset.
- Mid-frame vs: assert vs while 2 reads are in flight -> those words are dropped, the FIFO is empty, and the next frame's first pixel is address 0.
